host_feedback_tx: RTL and testbench

Host-side UART framer that returns game results to the player board, the reverse of the player-to-host guess link. It snapshots each game_logic result (guessed letter, hit/miss, counters, correct-position mask, game end) and packs it into a fixed frame. It then serializes the frame 8N1, LSB first, on a dedicated line. It holds one pending event while a frame is in flight, so back-to-back guesses are not lost.

---
 rtl/feedback_pkg.sv | 42 ++++
 rtl/feedback_serializer.sv | 75 +++++++
 rtl/host_feedback_tx.sv | 96 +++++++++
 tb/tb_host_feedback_tx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/feedback_pkg.sv
// rtl/feedback_pkg.sv - frame constants, state/event types and frame byte mux for host_feedback_tx
// FEEDBACK_CHKSUM_EN selects the 5-byte frame with a trailing XOR checksum.
package feedback_pkg;

    localparam logic [7:0] FB_SOF = 8'h7E;
`ifdef FEEDBACK_CHKSUM_EN
    localparam int FRAME_LEN = 5;
`else
    localparam int FRAME_LEN = 4;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    typedef struct packed {
        logic [7:0] letter;
        logic       gameEnd;
        logic       mistake;
        logic [2:0] correct;
        logic [2:0] incorrect;
        logic [4:0] indexCorrect;
    } fb_evt_t;

    function automatic logic [7:0] fb_status(input fb_evt_t e);
        return {e.gameEnd, e.mistake, e.correct, e.incorrect};
    endfunction

    function automatic logic [7:0] fb_byte(input fb_evt_t e, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = FB_SOF;
            3'd1:    b = e.letter;
            3'd2:    b = fb_status(e);
            3'd3:    b = {3'b000, e.indexCorrect};
`ifdef FEEDBACK_CHKSUM_EN
            3'd4:    b = e.letter ^ fb_status(e) ^ {3'b000, e.indexCorrect};
`endif
            default: b = FB_SOF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/feedback_serializer.sv
// rtl/feedback_serializer.sv - 8N1 LSB-first byte serializer with baud and bit counters
// A load in the last stop-bit cycle chains the next byte with no idle gap.
module feedback_serializer
    import feedback_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [7:0] byte_in,
    input  logic       load,
    output logic       bit_done,
    output logic       byte_done,
    output logic       busy,
    output logic       tx_serial
);

    localparam int             BW       = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    tx_state_t     state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;

    // bit_done strobes every bit boundary; byte_done marks the stop bit as the bit in flight.
    assign bit_done  = (state_q != IDLE) && (baud_q == BAUD_MAX);
    assign byte_done = (state_q == STOP);
    assign busy      = (state_q != IDLE);
    assign tx_serial = tx_q;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else if (load && (state_q == IDLE || (bit_done && byte_done))) begin
            state_q <= START;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= byte_in;
            tx_q    <= 1'b0;
        end else if (state_q != IDLE) begin
            if (!bit_done) begin
                baud_q <= baud_q + 1'b1;
            end else begin
                baud_q <= '0;
                case (state_q)
                    START: begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end
                    DATA: begin
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/host_feedback_tx.sv
// rtl/host_feedback_tx.sv - game result UART framer with one-entry pending slot
// Frame is SOF, letter, status, index (+ XOR checksum when FEEDBACK_CHKSUM_EN is defined).
module host_feedback_tx
    import feedback_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       evt_valid,
    input  logic [7:0] letter,
    input  logic       mistake,
    input  logic [2:0] correct,
    input  logic [2:0] incorrect,
    input  logic [4:0] indexCorrect,
    input  logic       gameEnd,
    output logic       tx_serial,
    output logic       busy,
    output logic       frame_done,
    output logic       drop
);

    fb_evt_t    evt_in, active_q, active_d, pend_q, pend_d;
    logic       pend_full_q, pend_full_d;
    logic       drop_q, drop_d;
    logic [2:0] byte_idx_q, byte_idx_d;
    logic       bit_done, byte_done, ser_busy;
    logic       byte_end, last_byte, start_frame, load;
    logic [7:0] byte_in;

    assign evt_in      = {letter, gameEnd, mistake, correct, incorrect, indexCorrect};
    assign byte_end    = bit_done && byte_done;
    assign last_byte   = (byte_idx_q == 3'(FRAME_LEN - 1));
    assign frame_done  = byte_end && last_byte;
    assign start_frame = (!ser_busy || frame_done) && (evt_valid || pend_full_q);
    assign load        = start_frame || (byte_end && !last_byte);
    // SOF is constant, so the first byte can launch before the snapshot lands in active_q.
    assign byte_in     = start_frame ? FB_SOF : fb_byte(active_q, byte_idx_q + 3'd1);
    assign busy        = ser_busy;
    assign drop        = drop_q;

    always_comb begin
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        byte_idx_d  = byte_idx_q;
        drop_d      = 1'b0;
        if (start_frame) begin
            byte_idx_d = '0;
            if (pend_full_q) begin
                active_d    = pend_q;
                pend_full_d = evt_valid;
                if (evt_valid) pend_d = evt_in;
            end else begin
                active_d = evt_in;
            end
        end else begin
            if (byte_end && !last_byte) byte_idx_d = byte_idx_q + 3'd1;
            if (evt_valid) begin
                pend_d      = evt_in;
                pend_full_d = 1'b1;
                drop_d      = pend_full_q;
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            active_q    <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            byte_idx_q  <= '0;
            drop_q      <= 1'b0;
        end else begin
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            byte_idx_q  <= byte_idx_d;
            drop_q      <= drop_d;
        end
    end

    feedback_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk      (clk),
        .nRst     (nRst),
        .byte_in  (byte_in),
        .load     (load),
        .bit_done (bit_done),
        .byte_done(byte_done),
        .busy     (ser_busy),
        .tx_serial(tx_serial)
    );

endmodule

// File: tb/tb_host_feedback_tx.sv
// tb/tb_host_feedback_tx.sv - directed self-checking bench for host_feedback_tx
`timescale 1ns/1ps
module tb_host_feedback_tx;

    localparam int CPB = 4;
`ifdef FEEDBACK_CHKSUM_EN
    localparam int FLEN = 5;
`else
    localparam int FLEN = 4;
`endif
    localparam int FCYC = FLEN * 10 * CPB;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       evt_valid = 1'b0;
    logic [7:0] letter = '0;
    logic       mistake = 1'b0;
    logic [2:0] correct = '0;
    logic [2:0] incorrect = '0;
    logic [4:0] indexCorrect = '0;
    logic       gameEnd = 1'b0;
    logic       tx_serial, busy, frame_done, drop;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         busy_cyc = 0;
    int         fd_cnt = 0;
    int         drop_cnt = 0;
    int         low_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic       rx_act = 1'b0;
    int         rx_cyc = 0;
    logic [7:0] rx_sh = '0;

    always #5 clk = ~clk;

    host_feedback_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .nRst        (nRst),
        .evt_valid   (evt_valid),
        .letter      (letter),
        .mistake     (mistake),
        .correct     (correct),
        .incorrect   (incorrect),
        .indexCorrect(indexCorrect),
        .gameEnd     (gameEnd),
        .tx_serial   (tx_serial),
        .busy        (busy),
        .frame_done  (frame_done),
        .drop        (drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // UART receiver: first low sample is offset 0, data bit b sampled at 4b+6, stop at 38.
    always @(negedge clk) begin
        if (busy) busy_cyc++;
        if (frame_done) fd_cnt++;
        if (drop) drop_cnt++;
        if (!tx_serial) low_cnt++;
        if (!nRst) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (!tx_serial) begin
                rx_act = 1'b1;
                rx_cyc = 0;
            end
        end else begin
            rx_cyc++;
            if (rx_cyc >= 6 && rx_cyc <= 34 && (rx_cyc % 4) == 2)
                rx_sh = {tx_serial, rx_sh[7:1]};
            if (rx_cyc == 38) begin
                chk("stop_bit", {31'b0, tx_serial}, 32'd1);
                rx_q.push_back(rx_sh);
                rx_act = 1'b0;
            end
        end
    end

    task automatic clear();
        busy_cyc = 0;
        fd_cnt   = 0;
        drop_cnt = 0;
        low_cnt  = 0;
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic send(input logic [7:0] l, input logic m, input logic [2:0] c,
                        input logic [2:0] ic, input logic [4:0] ix, input logic ge);
        @(negedge clk);
        letter = l; mistake = m; correct = c; incorrect = ic; indexCorrect = ix; gameEnd = ge;
        evt_valid = 1'b1;
        @(negedge clk);
        evt_valid = 1'b0;
        letter = 8'hFF; mistake = 1'b1; correct = 3'h7; incorrect = 3'h7; indexCorrect = 5'h1F; gameEnd = 1'b1;
    endtask

    task automatic push_frame(input logic [7:0] l, input logic [7:0] st, input logic [7:0] ix,
                              input logic [7:0] ck);
        exp_q.push_back(8'h7E);
        exp_q.push_back(l);
        exp_q.push_back(st);
        exp_q.push_back(ix);
`ifdef FEEDBACK_CHKSUM_EN
        exp_q.push_back(ck);
`else
        if (ck === 8'hxx) exp_q.push_back(8'h00);
`endif
    endtask

    task automatic cmp_rx(input string tag);
        chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), {24'b0, rx_q[i]}, {24'b0, exp_q[i]});
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_fd(input int budget);
        int n = 0;
        while (!frame_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("fd_timeout", {31'b0, frame_done}, 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'b0, tx_serial}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_fd", {31'b0, frame_done}, 32'd0);
        chk("rst_drop", {31'b0, drop}, 32'd0);
        nRst = 1'b1;
        repeat (3) @(negedge clk);

        // single hit event
        clear();
        send(8'h41, 1'b0, 3'd2, 3'd0, 5'b00100, 1'b0);
        chk("lat_tx", {31'b0, tx_serial}, 32'd0);
        chk("lat_busy", {31'b0, busy}, 32'd1);
        wait_idle(FCYC + 20);
        chk("a_busy_len", busy_cyc, FCYC);
        chk("a_fd", fd_cnt, 1);
        chk("a_drop", drop_cnt, 0);
        push_frame(8'h41, 8'h10, 8'h04, 8'h55);
        cmp_rx("a");

        // miss ending the game
        clear();
        send(8'h5A, 1'b1, 3'd1, 3'd6, 5'b00000, 1'b1);
        wait_idle(FCYC + 20);
        push_frame(8'h5A, 8'hCE, 8'h00, 8'h94);
        cmp_rx("miss");

        // back-to-back: second event ~30 cycles into frame 1
        clear();
        send(8'h41, 1'b0, 3'd2, 3'd0, 5'b00100, 1'b0);
        repeat (28) @(negedge clk);
        send(8'h42, 1'b1, 3'd2, 3'd1, 5'b00000, 1'b0);
        wait_fd(FCYC + 20);
        @(negedge clk);
        chk("b2b_start_tx", {31'b0, tx_serial}, 32'd0);
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        wait_idle(2 * FCYC + 20);
        chk("b2b_busy_len", busy_cyc, 2 * FCYC);
        chk("b2b_fd", fd_cnt, 2);
        chk("b2b_drop", drop_cnt, 0);
        push_frame(8'h41, 8'h10, 8'h04, 8'h55);
        push_frame(8'h42, 8'h51, 8'h00, 8'h13);
        cmp_rx("b2b");

        // three events in one frame: second is overwritten
        clear();
        send(8'h41, 1'b0, 3'd2, 3'd0, 5'b00100, 1'b0);
        repeat (10) @(negedge clk);
        send(8'h58, 1'b1, 3'd0, 3'd1, 5'b00000, 1'b0);
        repeat (10) @(negedge clk);
        send(8'h45, 1'b0, 3'd3, 3'd1, 5'b10010, 1'b0);
        wait_idle(3 * FCYC);
        chk("ovr_drop", drop_cnt, 1);
        chk("ovr_fd", fd_cnt, 2);
        chk("ovr_busy_len", busy_cyc, 2 * FCYC);
        push_frame(8'h41, 8'h10, 8'h04, 8'h55);
        push_frame(8'h45, 8'h19, 8'h12, 8'h4E);
        cmp_rx("ovr");

        // reset at cycle ~50 of a frame
        clear();
        send(8'h41, 1'b0, 3'd2, 3'd0, 5'b00100, 1'b0);
        repeat (48) @(negedge clk);
        #2 nRst = 1'b0;
        #1;
        chk("mrst_tx", {31'b0, tx_serial}, 32'd1);
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        low_cnt = 0;
        repeat (100) @(negedge clk);
        chk("mrst_low", low_cnt, 0);
        chk("mrst_fd", fd_cnt, 0);
        chk("mrst_busy_after", {31'b0, busy}, 32'd0);
        chk("mrst_nbytes", rx_q.size(), 1);

        // recovery after reset
        clear();
        send(8'h5A, 1'b1, 3'd1, 3'd6, 5'b00000, 1'b1);
        chk("rec_lat_tx", {31'b0, tx_serial}, 32'd0);
        wait_idle(FCYC + 20);
        push_frame(8'h5A, 8'hCE, 8'h00, 8'h94);
        cmp_rx("rec");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
